temp_pulse_gen: RTL

TEMP_PULSE_GEN -- requirements
Module: temp_pulse_gen

---
 rtl/temp_pulse_gen.sv | 114 +++++++++++
 1 files changed

// File: rtl/temp_pulse_gen.sv
// Sensor-style pulse train generator: each accepted low_cnt yields HIGH_CLKS high cycles then max(N,1) low cycles.
// Define TEMP_PULSE_REPEAT_EN to keep replaying the last frame while no new value is held.
module temp_pulse_gen #(
    parameter int unsigned HIGH_CLKS = 25,
    parameter int unsigned CNT_W     = 11
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [CNT_W-1:0] low_cnt,
    input  logic             low_valid,
    output logic             low_ready,
    output logic             pulse_out,
    output logic             busy,
    output logic             frame_done
);

    // The phase counter must hold both HIGH_CLKS-1 (up to 254) and the largest low count.
    localparam int unsigned PW = (CNT_W > 8) ? CNT_W : 8;

    typedef enum logic [1:0] {
        IDLE,
        HIGH,
        LOW
    } state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] hold_val;
    logic             hold_full;
    logic [CNT_W-1:0] n_val, n_next;
    logic [PW-1:0]    cnt, cnt_next;
    logic [PW-1:0]    high_last, low_last;
    logic             accept, pull;

    assign low_ready = !hold_full;
    assign accept    = low_valid && !hold_full;
    assign busy      = (state != IDLE);
    assign high_last = PW'(HIGH_CLKS - 1);
    // N=0 still gets one low cycle so adjacent high phases stay separated.
    assign low_last  = (n_val == '0) ? '0 : PW'(n_val - CNT_W'(1));

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        n_next     = n_val;
        pull       = 1'b0;
        frame_done = 1'b0;
        case (state)
            IDLE: begin
                if (hold_full) begin
                    pull       = 1'b1;
                    n_next     = hold_val;
                    cnt_next   = '0;
                    state_next = HIGH;
                end
            end
            HIGH: begin
                if (cnt == high_last) begin
                    cnt_next   = '0;
                    state_next = LOW;
                end else begin
                    cnt_next = cnt + PW'(1);
                end
            end
            LOW: begin
                if (cnt == low_last) begin
                    frame_done = 1'b1;
                    cnt_next   = '0;
                    if (hold_full) begin
                        pull       = 1'b1;
                        n_next     = hold_val;
                        state_next = HIGH;
                    end else begin
`ifdef TEMP_PULSE_REPEAT_EN
                        state_next = HIGH;
`else
                        state_next = IDLE;
`endif
                    end
                end else begin
                    cnt_next = cnt + PW'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            n_val     <= '0;
            pulse_out <= 1'b0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            n_val     <= n_next;
            pulse_out <= (state_next == HIGH);
        end
    end

    // Accept and pull are mutually exclusive: accept needs an empty register, pull a full one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_full <= 1'b0;
            hold_val  <= '0;
        end else if (accept) begin
            hold_full <= 1'b1;
            hold_val  <= low_cnt;
        end else if (pull) begin
            hold_full <= 1'b0;
        end
    end

endmodule
